// File: rtl/dffsre_pipe_bank.sv
// Bank of WIDTH enable/set/reset flops replicated over DEPTH pipeline stages.
// The stage-0 input can come from load, hold, serial shift or rotate; a saturating fill counter flags when the pipe is full.
module dffsre_pipe_bank #(
  parameter int                 WIDTH       = 10,
  parameter int                 DEPTH       = 2,
  parameter logic [WIDTH-1:0]   DEFAULT_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]   SET_VAL     = {WIDTH{1'b1}},
  localparam int                CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             S,
  input  logic             E,
  input  logic             sel,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D_in,
  input  logic             si,
  output logic [WIDTH-1:0] Q,
  output logic             so,
  output logic             q_valid,
  output logic [CNT_W-1:0] fill_cnt
);

  localparam logic [1:0] MODE_LOAD   = 2'b00;
  localparam logic [1:0] MODE_HOLD   = 2'b01;
  localparam logic [1:0] MODE_SHIFT  = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] stg [DEPTH];
  logic [WIDTH-1:0] stg0_nxt;
  logic [CNT_W-1:0] fill_nxt;

  // Left shift by one with a chosen fill bit; also covers WIDTH=1 without a negative slice.
  function automatic logic [WIDTH-1:0] shl1(input logic [WIDTH-1:0] v, input logic fill);
    logic [WIDTH-1:0] r;
    r[0] = fill;
    for (int i = 1; i < WIDTH; i++) r[i] = v[i-1];
    return r;
  endfunction

  always_comb begin
    stg0_nxt = stg[0];
    case (mode)
      MODE_LOAD:   stg0_nxt = sel ? D_in : DEFAULT_VAL;
      MODE_HOLD:   stg0_nxt = stg[0];
      MODE_SHIFT:  stg0_nxt = shl1(stg[0], si);
      MODE_ROTATE: stg0_nxt = shl1(stg[0], stg[0][WIDTH-1]);
      default:     stg0_nxt = stg[0];
    endcase
  end

  always_comb begin
    fill_nxt = fill_cnt;
    if (fill_cnt != FULL) fill_nxt = fill_cnt + CNT_W'(1);
  end

  // Reset outranks set; set wins over the clock for as long as S is low.
  always_ff @(posedge C or negedge R or negedge S) begin
    if (!R) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
      fill_cnt <= '0;
      q_valid  <= 1'b0;
    end else if (!S) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= SET_VAL;
      fill_cnt <= FULL;
      q_valid  <= 1'b1;
    end else if (E) begin
      stg[0] <= stg0_nxt;
      for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
      fill_cnt <= fill_nxt;
      q_valid  <= (fill_nxt == FULL);
    end
  end

  assign Q  = stg[DEPTH-1];
  assign so = stg[0][WIDTH-1];

endmodule
